// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/E decode stage.
//   - opcode constants, operand-select encodings
//   - exact-match SYSTEM words (ecall / ebreak / mret)
//   - bundle_t: the packed decoded bundle that the FIFO stores
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] OP1_ZERO = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_RS1  = 2'd2;

  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [1:0]  sel_op1;
    logic        sel_op2;
    logic        reg_write;
    logic        pc_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_csr;
    logic        is_ecall;
    logic        is_mret;
    logic        is_ebreak;
    logic        illegal;
    logic [2:0]  csr_waddr;
  } bundle_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I/E decoder.
//   ins    : instruction word
//   pc     : its address (carried through into the bundle)
//   bundle : decoded fields, immediate, control flags and illegal flag
// NR_REG = 16 flags any register field used by the format that is >= 16.
module decode_comb
  import decode_pkg::*;
#(
  parameter int NR_REG = 32
) (
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  output bundle_t     bundle
);

  localparam logic [5:0] NR_LIM = 6'(NR_REG);

  logic known, sys_bad, use_rs1, use_rs2, use_rd, bad_reg;

  always_comb begin
    bundle           = '0;
    bundle.pc        = pc;
    bundle.rs1       = ins[19:15];
    bundle.rs2       = ins[24:20];
    bundle.rd        = ins[11:7];
    bundle.opcode    = ins[6:0];
    bundle.func3     = ins[14:12];
    bundle.func7     = ins[31:25];
    bundle.csr_waddr = ins[22:20];
    bundle.sel_op1   = OP1_RS1;
    bundle.sel_op2   = OP2_IMM;
    known   = 1'b1;
    sys_bad = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (ins[6:0])
      OPC_LUI: begin
        bundle.imm = {ins[31:12], 12'b0};
        bundle.sel_op1 = OP1_ZERO;
        bundle.reg_write = 1'b1;
        use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        bundle.imm = {ins[31:12], 12'b0};
        bundle.sel_op1 = OP1_PC;
        bundle.reg_write = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        bundle.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        bundle.sel_op1 = OP1_PC;
        bundle.reg_write = 1'b1;
        bundle.pc_write = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        bundle.imm = {{20{ins[31]}}, ins[31:20]};
        bundle.reg_write = 1'b1;
        bundle.pc_write = 1'b1;
        use_rs1 = 1'b1;
        use_rd = 1'b1;
      end
      OPC_BRANCH: begin
        bundle.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        bundle.sel_op2 = OP2_RS2;
        bundle.pc_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        bundle.imm = {{20{ins[31]}}, ins[31:20]};
        bundle.reg_write = 1'b1;
        bundle.mem_read = 1'b1;
        use_rs1 = 1'b1;
        use_rd = 1'b1;
      end
      OPC_STORE: begin
        bundle.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bundle.mem_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle.imm = {{20{ins[31]}}, ins[31:20]};
        bundle.reg_write = 1'b1;
        use_rs1 = 1'b1;
        use_rd = 1'b1;
      end
      OPC_OP: begin
        bundle.sel_op2 = OP2_RS2;
        bundle.reg_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd = 1'b1;
      end
      OPC_MISC_MEM: begin
        // FENCE: I-format layout, no architectural effect here
        bundle.imm = {{20{ins[31]}}, ins[31:20]};
        use_rs1 = 1'b1;
        use_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        if (ins[14:12] != 3'b000) begin
          bundle.is_csr = 1'b1;
          bundle.reg_write = 1'b1;
          use_rd = 1'b1;
          // func3[2] selects the uimm form: the rs1 field is data, not a register
          use_rs1 = ~ins[14];
        end else begin
          bundle.is_ecall  = (ins == INS_ECALL);
          bundle.is_ebreak = (ins == INS_EBREAK);
          bundle.is_mret   = (ins == INS_MRET);
          sys_bad = ~(bundle.is_ecall | bundle.is_ebreak | bundle.is_mret);
        end
      end
      default: known = 1'b0;
    endcase

    bad_reg = (use_rs1 && ({1'b0, ins[19:15]} >= NR_LIM)) ||
              (use_rs2 && ({1'b0, ins[24:20]} >= NR_LIM)) ||
              (use_rd  && ({1'b0, ins[11:7]}  >= NR_LIM));
    bundle.illegal = ~known | (ins == 32'h0) | sys_bad | bad_reg;

    // an illegal word must not have any side effect downstream
    if (bundle.illegal) begin
      bundle.reg_write = 1'b0;
      bundle.pc_write  = 1'b0;
      bundle.mem_read  = 1'b0;
      bundle.mem_write = 1'b0;
      bundle.is_csr    = 1'b0;
      bundle.is_ecall  = 1'b0;
      bundle.is_mret   = 1'b0;
      bundle.is_ebreak = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes ins at accept time and buffers decoded bundles in a
// DEPTH-entry FIFO between fetch and execute.
//   clk, rst (sync, active high), flush (sync discard of everything)
//   fetch side  : in_valid / in_ready, ins, pc
//   execute side: out_valid / out_ready, head bundle fields (out_pc is the
//                 bundle's pc, renamed because the input already owns "pc")
// Bundle outputs read 0 whenever out_valid is low.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NR_REG = 32,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [1:0]  sel_op1,
  output logic        sel_op2,
  output logic        reg_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        is_csr,
  output logic        is_ecall,
  output logic        is_mret,
  output logic        is_ebreak,
  output logic        illegal,
  output logic [2:0]  csr_waddr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  bundle_t       dec, head;
  bundle_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  decode_comb #(.NR_REG(NR_REG)) u_dec (.ins(ins), .pc(pc), .bundle(dec));

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // data storage needs no reset: count/pointers gate every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_pc    = head.pc;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign imm       = head.imm;
  assign opcode    = head.opcode;
  assign func3     = head.func3;
  assign func7     = head.func7;
  assign sel_op1   = head.sel_op1;
  assign sel_op2   = head.sel_op2;
  assign reg_write = head.reg_write;
  assign pc_write  = head.pc_write;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign is_csr    = head.is_csr;
  assign is_ecall  = head.is_ecall;
  assign is_mret   = head.is_mret;
  assign is_ebreak = head.is_ebreak;
  assign illegal   = head.illegal;
  assign csr_waddr = head.csr_waddr;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter NR_REG, default 32, giving the architectural register count; legal values are 16 (RV32E) and 32 (RV32I).
REQ-002 SHALL have parameter DEPTH, default 2, giving the decoded-bundle buffer depth; legal values are powers of 2 and at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all buffered and incoming bundles.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), ins (input, 32) and pc (input, 32): the fetch-side handshake, instruction word and its address.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the execute-side handshake.
REQ-008 SHALL have output ports for the head bundle: pc (32), rs1/rs2/rd (5 each), imm (32), opcode (7), func3 (3), func7 (7), sel_op1 (2), sel_op2 (1), and single-bit reg_write, pc_write, mem_read, mem_write, is_csr, is_ecall, is_mret, is_ebreak, illegal.
REQ-009 SHALL have output port csr_waddr, 3 bits: ins[22:20] of the head bundle.

Function
REQ-010 Decode SHALL be combinational on ins at accept time; only decoded bundles are stored.
REQ-011 Immediates SHALL use standard RV32I I/S/B/U/J sign-extension, selected by opcode; imm SHALL be 0 for R-type, CSR and SYSTEM opcodes.
REQ-012 sel_op1 SHALL be 0 (zero) for LUI, 1 (pc) for AUIPC/JAL, and 2 (rs1) for all other opcodes.
REQ-013 sel_op2 SHALL be 0 (rs2) for BRANCH/R-type and 1 (imm) for all other opcodes.
REQ-014 reg_write SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and SYSTEM with func3!=0.
REQ-015 pc_write SHALL be 1 for JAL/JALR/BRANCH; mem_read SHALL be 1 for LOAD; mem_write SHALL be 1 for STORE.
REQ-016 is_csr SHALL be 1 for SYSTEM with func3!=0; is_ecall, is_ebreak and is_mret SHALL be 1 for exact match on 0x00000073, 0x00100073 and 0x30200073 respectively.
REQ-017 illegal SHALL be 1 for any of: an opcode outside the RV32I set; ins==0; a SYSTEM func3==0 word that is not ecall/ebreak/mret; or any register field used by the format that is >= NR_REG.
REQ-018 When illegal=1, reg_write, pc_write, mem_read, mem_write, is_csr, is_ecall, is_mret and is_ebreak SHALL all be 0.
REQ-019 The buffer SHALL be a FIFO of DEPTH bundles with an occupancy count.
REQ-020 in_ready SHALL be (count<DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be (count>0).
REQ-022 Push SHALL occur when in_valid&in_ready; pop SHALL occur when out_valid&out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-023 Latency SHALL be 1 cycle: a bundle accepted at edge N SHALL be visible on the outputs after edge N.
REQ-024 Output order SHALL equal accept order; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 When out_valid=0, all bundle outputs SHALL be 0.
REQ-026 flush SHALL clear count and both pointers, drop a same-cycle push and override a same-cycle pop; flush SHALL take priority over all other events.

Reset
REQ-027 rst SHALL clear count and pointers, giving in_ready=1, out_valid=0 and all bundle outputs 0 in the cycle after the edge.
REQ-028 rst asserted mid-stream SHALL discard all buffered bundles; no partial bundle SHALL be emitted afterward.
REQ-029 Buffer data storage SHALL require no reset.

Structure
REQ-030 Package decode_pkg SHALL hold the opcode constants, the sel_op1/sel_op2 encodings, the ecall/ebreak/mret words, and the packed decoded-bundle struct.
REQ-031 Pure decode logic SHALL live in sub-module decode_comb (ins -> bundle, parameter NR_REG); decode_stage SHALL hold the FIFO and handshake.

Verification
REQ-032 ins=0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, reg_write=1, sel_op1=2, sel_op2=1, illegal=0.
REQ-033 ins=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, pc_write=1, sel_op2=0, reg_write=0.
REQ-034 NR_REG=16, ins=0x011000B3 (add x1,x0,x17) -> illegal=1, reg_write=0; with NR_REG=32 the same word gives illegal=0, reg_write=1.
REQ-035 DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after the second; release out_ready -> bundles emerge in order and the third is then accepted.
REQ-036 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, in_ready=1, and the incoming word is never emitted.
REQ-037 Words 0x00000073, 0x00100073, 0x30200073 and 0x00000000 -> is_ecall, is_ebreak and is_mret asserted respectively for the first three, and illegal=1 for the last.
